// File: rtl/imem_debug_port_arbiter_pkg.sv
// Shared constants and types for the instruction-RAM debug port arbiter.
//   DEPTH_WORDS_DEF : default instruction RAM depth in 32-bit words
//   ADDR_W/DATA_W/WE_W : bus widths of the RAM port B and requester ports
//   req_id_t        : requester identity (m0 = UART loader, m1 = debug reader)
//   resp_t          : response bookkeeping captured at the accept edge
//   is_reject()     : misaligned-write / out-of-range access check
package imem_debug_port_arbiter_pkg;

   localparam int unsigned DEPTH_WORDS_DEF = 4096;
   localparam int unsigned ADDR_W          = 32;
   localparam int unsigned DATA_W          = 32;
   localparam int unsigned WE_W            = 4;

   typedef enum logic {
      REQ_M0 = 1'b0,
      REQ_M1 = 1'b1
   } req_id_t;

   typedef struct packed {
      logic    vld;
      req_id_t id;
      logic    is_read;
      logic    err;
   } resp_t;

   // Reads ignore the byte offset; writes must be word aligned.
   function automatic logic is_reject(input logic [ADDR_W-1:0] addr,
                                      input logic [WE_W-1:0]   we,
                                      input int unsigned       depth);
      logic [31:0] w_word;
      w_word = {2'b00, addr[ADDR_W-1:2]};
      return ((we != '0) && (addr[1:0] != 2'b00)) || (w_word >= depth);
   endfunction

endpackage

// File: rtl/imem_debug_port_arbiter_if.sv
// Requester-side bus of the instruction-RAM debug port.
//   valid/addr/wdata/we : request, held stable by the requester until ready
//   ready               : request accepted this cycle
//   rvalid/rdata/err    : one-cycle response pulse, one cycle after accept
// master = requester side, slave = arbiter side.
interface imem_debug_port_arbiter_if import imem_debug_port_arbiter_pkg::*; ;

   logic              valid;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [WE_W-1:0]   we;
   logic              ready;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;
   logic              err;

   modport master (output valid, addr, wdata, we,
                   input  ready, rvalid, rdata, err);
   modport slave  (input  valid, addr, wdata, we,
                   output ready, rvalid, rdata, err);

endinterface

// File: rtl/rr_burst_arb2.sv
// Two-way round-robin arbiter with bounded bursts.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_req[1:0]   : request valids, bit X = requester X
//   o_gnt_vld    : a grant (and therefore an accept) happens this cycle
//   o_gnt_id     : granted requester
// Under contention the last winner keeps the port while 0 < burst < MAX_BURST,
// otherwise the other requester takes over. Any idle cycle ends the burst.
module rr_burst_arb2 import imem_debug_port_arbiter_pkg::*; #(
   parameter int unsigned MAX_BURST = 4
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [1:0] i_req,
   output logic       o_gnt_vld,
   output req_id_t    o_gnt_id
);

   localparam int unsigned    CW   = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0]  MAXC = CW'(MAX_BURST);

   req_id_t       r_last;
   logic [CW-1:0] r_cnt;
   logic          w_hold;

   always_comb begin
      o_gnt_vld = 1'b0;
      o_gnt_id  = REQ_M0;
      w_hold    = (r_cnt != '0) && (r_cnt < MAXC);
      if (!i_rst) begin
         case (i_req)
            2'b01: begin o_gnt_vld = 1'b1; o_gnt_id = REQ_M0; end
            2'b10: begin o_gnt_vld = 1'b1; o_gnt_id = REQ_M1; end
            2'b11: begin
               o_gnt_vld = 1'b1;
               o_gnt_id  = w_hold ? r_last : req_id_t'(~r_last);
            end
            default: ;
         endcase
      end
   end

   // r_last resets to m1 so that m0 wins the first contention.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_last <= REQ_M1;
         r_cnt  <= '0;
      end else if (!o_gnt_vld) begin
         r_cnt  <= '0;
      end else if (o_gnt_id == r_last) begin
         if (r_cnt != MAXC) r_cnt <= r_cnt + 1'b1;
      end else begin
         r_cnt  <= CW'(1);
         r_last <= o_gnt_id;
      end
   end

endmodule

// File: rtl/imem_debug_port_arbiter.sv
// Shares port B of the instruction RAM between the UART program loader (m0)
// and the debug/trace reader (m1).
//   i_clk, i_rst    : clock, synchronous active-high reset
//   m0, m1          : requester buses (slave modport)
//   o_ram_a2/wd2/we2: RAM port B address / write data / byte enables
//   i_ram_rd2       : RAM port B read data, valid the cycle after the address edge
//   o_busy          : a request is presented or a response is pending
// One beat is accepted per cycle; its response appears exactly one cycle later.
// Misaligned writes and out-of-range accesses never reach the RAM and answer err=1.
module imem_debug_port_arbiter import imem_debug_port_arbiter_pkg::*; #(
   parameter int unsigned MAX_BURST   = 4,
   parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   imem_debug_port_arbiter_if.slave  m0,
   imem_debug_port_arbiter_if.slave  m1,
   output logic [ADDR_W-1:0]         o_ram_a2,
   output logic [DATA_W-1:0]         o_ram_wd2,
   output logic [WE_W-1:0]           o_ram_we2,
   input  logic [DATA_W-1:0]         i_ram_rd2,
   output logic                      o_busy
);

   logic              w_gnt_vld;
   req_id_t           w_gnt_id;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_wdata;
   logic [WE_W-1:0]   w_we;
   logic              w_reject;
   logic [DATA_W-1:0] w_rdata;
   logic              w_rv0, w_rv1;
   resp_t             r_resp;

   // Grant is already forced off during reset inside the arbiter.
   rr_burst_arb2 #(.MAX_BURST(MAX_BURST)) u_arb (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_req     ({m1.valid, m0.valid}),
      .o_gnt_vld (w_gnt_vld),
      .o_gnt_id  (w_gnt_id)
   );

   always_comb begin
      w_addr  = m0.addr;
      w_wdata = m0.wdata;
      w_we    = m0.we;
      if (w_gnt_id == REQ_M1) begin
         w_addr  = m1.addr;
         w_wdata = m1.wdata;
         w_we    = m1.we;
      end
   end

   assign w_reject  = is_reject(w_addr, w_we, DEPTH_WORDS);

   assign m0.ready  = w_gnt_vld && (w_gnt_id == REQ_M0);
   assign m1.ready  = w_gnt_vld && (w_gnt_id == REQ_M1);

   assign o_ram_a2  = w_gnt_vld ? w_addr  : '0;
   assign o_ram_wd2 = w_gnt_vld ? w_wdata : '0;
   assign o_ram_we2 = (w_gnt_vld && !w_reject) ? w_we : '0;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_resp <= '0;
      end else begin
         r_resp.vld     <= w_gnt_vld;
         r_resp.id      <= w_gnt_id;
         r_resp.is_read <= (w_we == '0);
         r_resp.err     <= w_reject;
      end
   end

   // Response outputs are masked during reset so a pending beat is dropped.
   assign w_rdata   = (r_resp.is_read && !r_resp.err) ? i_ram_rd2 : '0;
   assign w_rv0     = !i_rst && r_resp.vld && (r_resp.id == REQ_M0);
   assign w_rv1     = !i_rst && r_resp.vld && (r_resp.id == REQ_M1);

   assign m0.rvalid = w_rv0;
   assign m0.rdata  = w_rv0 ? w_rdata : '0;
   assign m0.err    = w_rv0 && r_resp.err;
   assign m1.rvalid = w_rv1;
   assign m1.rdata  = w_rv1 ? w_rdata : '0;
   assign m1.err    = w_rv1 && r_resp.err;

   assign o_busy    = !i_rst && (m0.valid || m1.valid || r_resp.vld);

endmodule

// File: tb/tb_imem_debug_port_arbiter.sv
// Directed bench for imem_debug_port_arbiter with a behavioural synchronous RAM.
module tb_imem_debug_port_arbiter;
   import imem_debug_port_arbiter_pkg::*;

   logic        clk;
   logic        rst;
   logic [31:0] ram_a2, ram_wd2, ram_rd2;
   logic [3:0]  ram_we2;
   logic        busy;
   int          n_chk = 0;
   int          n_fail = 0;
   int          exp_g [0:9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
   logic [31:0] mem [0:4095];

   imem_debug_port_arbiter_if m0_if ();
   imem_debug_port_arbiter_if m1_if ();

   imem_debug_port_arbiter #(.MAX_BURST(4), .DEPTH_WORDS(4096)) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .m0        (m0_if.slave),
      .m1        (m1_if.slave),
      .o_ram_a2  (ram_a2),
      .o_ram_wd2 (ram_wd2),
      .o_ram_we2 (ram_we2),
      .i_ram_rd2 (ram_rd2),
      .o_busy    (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Synchronous RAM model; known contents are reloaded whenever reset is high.
   always @(posedge clk) begin
      if (rst) begin
         mem[0] <= 32'hBAD0_0000;
         mem[1] <= 32'h1111_0001;
         mem[4] <= 32'hDEAD_BEEF;
         mem[5] <= 32'h5555_0005;
      end else begin
         for (int b = 0; b < 4; b++)
            if (ram_we2[b]) mem[ram_a2[13:2]][b*8 +: 8] <= ram_wd2[b*8 +: 8];
      end
      ram_rd2 <= mem[ram_a2[13:2]];
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      m0_if.valid = 1'b0; m0_if.addr = '0; m0_if.wdata = '0; m0_if.we = '0;
      m1_if.valid = 1'b0; m1_if.addr = '0; m1_if.wdata = '0; m1_if.we = '0;
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1;
      m0_if.valid = 1'b1; m0_if.addr = 32'h10; m0_if.we = 4'hF;
      step(); step();
      n_chk++; if (m0_if.ready !== 1'b0) begin n_fail++; $display("FAIL rst_m0_ready got %0b want 0", m0_if.ready); end
      n_chk++; if (ram_we2 !== 4'h0) begin n_fail++; $display("FAIL rst_ram_we2 got %0h want 0", ram_we2); end
      n_chk++; if (ram_a2 !== 32'h0) begin n_fail++; $display("FAIL rst_ram_a2 got %0h want 0", ram_a2); end
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %0b want 0", busy); end
      idle();
      step();
      rst = 1'b0;
      #1;
      n_chk++; if ({m0_if.ready, m0_if.rvalid, m0_if.err, m1_if.ready, m1_if.rvalid, m1_if.err} !== 6'b0)
         begin n_fail++; $display("FAIL post_rst_flags got %b want 000000", {m0_if.ready, m0_if.rvalid, m0_if.err, m1_if.ready, m1_if.rvalid, m1_if.err}); end
      n_chk++; if ({m0_if.rdata, m1_if.rdata, ram_wd2} !== 96'h0) begin n_fail++; $display("FAIL post_rst_data got %h want 0", {m0_if.rdata, m1_if.rdata, ram_wd2}); end
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_rst_busy got %0b want 0", busy); end
   endtask

   task automatic test_read();
      step();
      m0_if.valid = 1'b1; m0_if.addr = 32'h10; m0_if.we = 4'h0;
      #1;
      n_chk++; if (m0_if.ready !== 1'b1) begin n_fail++; $display("FAIL rd_ready got %0b want 1", m0_if.ready); end
      n_chk++; if (ram_a2 !== 32'h10) begin n_fail++; $display("FAIL rd_a2 got %0h want 10", ram_a2); end
      n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rd_busy got %0b want 1", busy); end
      step();
      idle();
      #1;
      n_chk++; if (m0_if.rvalid !== 1'b1) begin n_fail++; $display("FAIL rd_rvalid got %0b want 1", m0_if.rvalid); end
      n_chk++; if (m0_if.rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_rdata got %h want deadbeef", m0_if.rdata); end
      n_chk++; if (m0_if.err !== 1'b0) begin n_fail++; $display("FAIL rd_err got %0b want 0", m0_if.err); end
      n_chk++; if (m1_if.rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_m1_rvalid got %0b want 0", m1_if.rvalid); end
      step();
      n_chk++; if (m0_if.rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_pulse got %0b want 0", m0_if.rvalid); end
   endtask

   task automatic test_burst();
      logic [31:0] exp_d;
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      m0_if.valid = 1'b1; m0_if.addr = 32'h10;
      m1_if.valid = 1'b1; m1_if.addr = 32'h14;
      for (int i = 0; i < 10; i++) begin
         #1;
         n_chk++; if ({m1_if.ready, m0_if.ready} !== ((exp_g[i] == 1) ? 2'b10 : 2'b01))
            begin n_fail++; $display("FAIL burst_grant[%0d] got m1m0=%b want m%0d", i, {m1_if.ready, m0_if.ready}, exp_g[i]); end
         if (i > 0) begin
            exp_d = (exp_g[i-1] == 1) ? 32'h5555_0005 : 32'hDEAD_BEEF;
            n_chk++; if ({m1_if.rvalid, m0_if.rvalid} !== ((exp_g[i-1] == 1) ? 2'b10 : 2'b01))
               begin n_fail++; $display("FAIL burst_rvalid[%0d] got m1m0=%b want m%0d", i, {m1_if.rvalid, m0_if.rvalid}, exp_g[i-1]); end
            n_chk++; if ((m0_if.rdata | m1_if.rdata) !== exp_d)
               begin n_fail++; $display("FAIL burst_rdata[%0d] got %h want %h", i, m0_if.rdata | m1_if.rdata, exp_d); end
         end
         step();
      end
      idle();
      #1;
      n_chk++; if ({m1_if.rvalid, m0_if.rvalid} !== 2'b01) begin n_fail++; $display("FAIL burst_last_rvalid got %b want 01", {m1_if.rvalid, m0_if.rvalid}); end
      n_chk++; if (m0_if.rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL burst_last_rdata got %h want deadbeef", m0_if.rdata); end
      step();
   endtask

   task automatic test_misaligned();
      m0_if.valid = 1'b1; m0_if.addr = 32'h6; m0_if.wdata = 32'hAAAA_AAAA; m0_if.we = 4'hF;
      #1;
      n_chk++; if (m0_if.ready !== 1'b1) begin n_fail++; $display("FAIL mis_ready got %0b want 1", m0_if.ready); end
      n_chk++; if (ram_we2 !== 4'h0) begin n_fail++; $display("FAIL mis_we2 got %0h want 0", ram_we2); end
      step();
      idle();
      #1;
      n_chk++; if (m0_if.rvalid !== 1'b1) begin n_fail++; $display("FAIL mis_rvalid got %0b want 1", m0_if.rvalid); end
      n_chk++; if (m0_if.err !== 1'b1) begin n_fail++; $display("FAIL mis_err got %0b want 1", m0_if.err); end
      n_chk++; if (m0_if.rdata !== 32'h0) begin n_fail++; $display("FAIL mis_rdata got %h want 0", m0_if.rdata); end
      n_chk++; if (mem[1] !== 32'h1111_0001) begin n_fail++; $display("FAIL mis_word1 got %h want 11110001", mem[1]); end
      step();
   endtask

   task automatic test_oob();
      m1_if.valid = 1'b1; m1_if.addr = 32'h4000; m1_if.we = 4'h0;
      #1;
      n_chk++; if ({m1_if.ready, m0_if.ready} !== 2'b10) begin n_fail++; $display("FAIL oob_ready got %b want 10", {m1_if.ready, m0_if.ready}); end
      step();
      idle();
      #1;
      n_chk++; if (m1_if.rvalid !== 1'b1) begin n_fail++; $display("FAIL oob_rvalid got %0b want 1", m1_if.rvalid); end
      n_chk++; if (m1_if.err !== 1'b1) begin n_fail++; $display("FAIL oob_err got %0b want 1", m1_if.err); end
      n_chk++; if (m1_if.rdata !== 32'h0) begin n_fail++; $display("FAIL oob_rdata got %h want 0", m1_if.rdata); end
      n_chk++; if ({m0_if.rvalid, m0_if.err} !== 2'b00) begin n_fail++; $display("FAIL oob_m0_clean got %b want 00", {m0_if.rvalid, m0_if.err}); end
      step();
   endtask

   task automatic test_back_to_back();
      m0_if.valid = 1'b1; m0_if.addr = 32'h20; m0_if.wdata = 32'h1234_5678; m0_if.we = 4'hF;
      #1;
      n_chk++; if (ram_we2 !== 4'hF) begin n_fail++; $display("FAIL b2b_we2 got %0h want f", ram_we2); end
      n_chk++; if (ram_wd2 !== 32'h1234_5678) begin n_fail++; $display("FAIL b2b_wd2 got %h want 12345678", ram_wd2); end
      step();
      m0_if.wdata = '0; m0_if.we = 4'h0;
      #1;
      n_chk++; if ({m0_if.ready, m0_if.rvalid, m0_if.err} !== 3'b110) begin n_fail++; $display("FAIL b2b_overlap got %b want 110", {m0_if.ready, m0_if.rvalid, m0_if.err}); end
      n_chk++; if (m0_if.rdata !== 32'h0) begin n_fail++; $display("FAIL b2b_wr_rdata got %h want 0", m0_if.rdata); end
      step();
      idle();
      #1;
      n_chk++; if (m0_if.rvalid !== 1'b1) begin n_fail++; $display("FAIL b2b_rd_rvalid got %0b want 1", m0_if.rvalid); end
      n_chk++; if (m0_if.rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL b2b_rd_rdata got %h want 12345678", m0_if.rdata); end
      step();
   endtask

   task automatic test_reset_mid();
      m0_if.valid = 1'b1; m0_if.addr = 32'h10; m0_if.we = 4'h0;
      #1;
      n_chk++; if (m0_if.ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready got %0b want 1", m0_if.ready); end
      step();
      idle();
      rst = 1'b1;
      #1;
      n_chk++; if (m0_if.rvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_rvalid_in_rst got %0b want 0", m0_if.rvalid); end
      step();
      rst = 1'b0;
      m0_if.valid = 1'b1; m0_if.addr = 32'h10;
      m1_if.valid = 1'b1; m1_if.addr = 32'h14;
      #1;
      n_chk++; if (m0_if.rvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_rvalid_after got %0b want 0", m0_if.rvalid); end
      n_chk++; if ({m1_if.ready, m0_if.ready} !== 2'b01) begin n_fail++; $display("FAIL rmid_first_grant got %b want 01", {m1_if.ready, m0_if.ready}); end
      step();
      idle();
      step();
   endtask

   initial begin
      rst = 1'b1;
      idle();
      test_reset();
      test_read();
      test_burst();
      test_misaligned();
      test_oob();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
